// File: rtl/count_fsm_scheduler.sv
// -----------------------------------------------------------------------------
// count_fsm_scheduler
//
// Round-robin scheduler that shares one 4-state pulse-counting FSM among four
// requesters. A granted requester gets a burst of 1-4 consecutive x pulses
// driven into the shared FSM. The shared FSM output is then sampled and
// handed back to that requester together with a one-cycle done strobe.
// This block is the only driver of the shared FSM's x_in.
//
// Ports
//   clock   in   1  rising-edge clock
//   reset   in   1  asynchronous, active-low reset
//   req     in   4  request level per requester (bit i = requester i)
//   len     in   8  packed burst lengths, len[2i+1:2i]; pulse count = field+1
//   y_in    in   1  y_out of the shared FSM
//   x_out   out  1  drives x_in of the shared FSM
//   grant   out  4  one-hot owner of the shared FSM, 0 when idle
//   done    out  4  one-cycle strobe to the owner at transaction end
//   result  out  1  y_in sampled after the burst, held until the next done
//   busy    out  1  high in every state except IDLE
// -----------------------------------------------------------------------------
module count_fsm_scheduler #(
  parameter int NREQ = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [2*NREQ-1:0] len,
  input  logic             y_in,
  output logic             x_out,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic             result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  last;
  logic [1:0]  winner;
  logic [1:0]  winner_len;
  logic [3:0]  winner_onehot;

  // Round-robin pick: search starts one past the previous winner and wraps.
  // i == 4 lands back on 'last' itself, so the previous winner is considered
  // last of all.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] w;
    logic [1:0] idx;
    logic       found;
    w     = l;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = l + i[1:0];
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // Arbitration result and the winner's burst length, evaluated every cycle
  // but only consumed on the IDLE -> PULSE edge.
  always_comb begin
    winner        = rr_pick(req, last);
    winner_len    = len[{winner, 1'b0} +: 2];
    winner_onehot = 4'b0001 << winner;
  end

  // x_out is decoded straight from the registered state, so it is glitch-free.
  assign x_out = (state == PULSE);

  // Scheduler FSM with registered grant/done/result/busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      last   <= 2'd3;
      grant  <= 4'b0000;
      done   <= 4'b0000;
      result <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            state <= PULSE;
            grant <= winner_onehot;
            cnt   <= winner_len;
            last  <= winner;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        PULSE: begin
          // cnt starts at field, so PULSE lasts field+1 cycles.
          if (cnt == 2'd0) begin
            state <= SAMPLE;
          end else begin
            cnt   <= cnt - 2'd1;
            state <= PULSE;
          end
        end
        SAMPLE: begin
          // The shared FSM has absorbed the last pulse on the previous edge.
          result <= y_in;
          done   <= grant;
          state  <= DONE;
        end
        DONE: begin
          grant <= 4'b0000;
          done  <= 4'b0000;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
          done  <= 4'b0000;
          busy  <= 1'b0;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_fsm_scheduler.sv
// -----------------------------------------------------------------------------
// Directed testbench for count_fsm_scheduler. Includes a model of the shared
// 4-state pulse counter (S0->S1->S2->S3->S1 on each x pulse, y = state==S3)
// sharing the same reset net. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_count_fsm_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [7:0] len;
  logic       y_in;
  logic       x_out;
  logic [3:0] grant;
  logic [3:0] done;
  logic       result;
  logic       busy;

  int checks;
  int errors;

  count_fsm_scheduler dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .len    (len),
    .y_in   (y_in),
    .x_out  (x_out),
    .grant  (grant),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  // Shared pulse-counting FSM.
  logic [1:0] fsm_s;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fsm_s <= 2'd0;
    else if (x_out) fsm_s <= (fsm_s == 2'd3) ? 2'd1 : fsm_s + 2'd1;
  end
  assign y_in = (fsm_s == 2'd3);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One full transaction starting from IDLE; req dropped once done is seen.
  task automatic run_txn(input string tag, input logic [3:0] r, input logic [7:0] l,
                         input logic [3:0] exp_grant, input int pulses, input logic exp_res);
    int n;
    req = r;
    len = l;
    step();
    check({tag, "_grant"}, grant, exp_grant);
    check({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (x_out && n < 10) begin
      n++;
      step();
    end
    check({tag, "_pulses"}, n, pulses);
    check({tag, "_sample_done"}, done, 4'b0000);
    step();
    check({tag, "_done"}, done, exp_grant);
    check({tag, "_result"}, result, exp_res);
    req = 4'b0000;
    step();
    check({tag, "_idle_done"}, done, 4'b0000);
    check({tag, "_idle_grant"}, grant, 4'b0000);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  logic [3:0] rr_exp [5];
  logic       rr_res [5];

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    req    = 4'b0000;
    len    = 8'h00;
    #12;
    check("rst_grant", grant, 4'b0000);
    check("rst_done", done, 4'b0000);
    check("rst_x", x_out, 1'b0);
    check("rst_result", result, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Test 1: 3 pulses from S0 -> S3, result 1.
    run_txn("t1", 4'b0001, 8'h02, 4'b0001, 3, 1'b1);
    // Test 2: 4 pulses wraps to S1 -> 0; then 2 pulses S1 -> S3 -> 1.
    run_txn("t2a", 4'b0001, 8'h03, 4'b0001, 4, 1'b0);
    run_txn("t2b", 4'b0001, 8'h01, 4'b0001, 2, 1'b1);

    // Test 3: all request, fields 0, round-robin from requester 0.
    do_reset();
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    rr_res[0] = 1'b0; rr_res[1] = 1'b0; rr_res[2] = 1'b1;
    rr_res[3] = 1'b0; rr_res[4] = 1'b0;
    req = 4'b1111;
    len = 8'h00;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_grant_pulse", grant, rr_exp[k]);
      check("rr_x", x_out, 1'b1);
      step();
      check("rr_grant_sample", grant, rr_exp[k]);
      check("rr_x_sample", x_out, 1'b0);
      step();
      check("rr_done", done, rr_exp[k]);
      check("rr_result", result, rr_res[k]);
      if (k == 4) req = 4'b0000;
      step();
      check("rr_idle_grant", grant, 4'b0000);
      check("rr_idle_busy", busy, 1'b0);
    end

    // Test 4: serve requester 1, then 0101 -> requester 2 before 0.
    // Shared FSM at S2 here.
    run_txn("t4a", 4'b0010, 8'h00, 4'b0010, 1, 1'b1);
    run_txn("t4b", 4'b0101, 8'h00, 4'b0100, 1, 1'b0);
    run_txn("t4c", 4'b0101, 8'h00, 4'b0001, 1, 1'b0);

    // Test 5: req and len change mid-PULSE; FSM S2 + 4 pulses -> S3.
    req = 4'b0001;
    len = 8'h03;
    step();
    check("t5_grant", grant, 4'b0001);
    req = 4'b0000;
    len = 8'hFC;
    n = 0;
    while (x_out && n < 10) begin
      n++;
      step();
    end
    check("t5_pulses", n, 4);
    step();
    check("t5_done", done, 4'b0001);
    check("t5_result", result, 1'b1);
    step();
    check("t5_idle_grant", grant, 4'b0000);

    // Test 6: async reset in the 2nd PULSE cycle.
    req = 4'b0001;
    len = 8'h03;
    step();
    step();
    check("t6_x_before", x_out, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t6_x", x_out, 1'b0);
    check("t6_grant", grant, 4'b0000);
    check("t6_busy", busy, 1'b0);
    req = 4'b0010;
    len = 8'h00;
    step();
    check("t6_no_done", done, 4'b0000);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("t6_new_grant", grant, 4'b0010);
    check("t6_new_x", x_out, 1'b1);
    step();
    step();
    check("t6_new_done", done, 4'b0010);
    check("t6_new_result", result, 1'b0);
    req = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
